lane_pack_buffer: RTL and testbench

Parametrised serial-to-parallel packer. Byte/word writes land in lane slots of an assembly register. Completed frames move to an output holding register with a valid/ready handshake, so the next frame can fill while the current one drains. Supports auto-increment and addressed lane modes, partial-frame flush and a per-lane written mask. Sits between byte-wide producers (UART/SPI receive paths) and wide consumers.

---
 rtl/lane_pack_pkg.sv | 21 ++
 rtl/lane_onehot_dec.sv | 15 +
 rtl/lane_pack_buffer.sv | 169 ++++++++++++++++
 tb/tb_lane_pack_buffer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_pack_pkg.sv
// Shared types and helpers for the lane packer: FSM states, write-mode encodings, popcount.
package lane_pack_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam logic MODE_AUTO = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

  // Sized for the largest supported frame (64 lanes); callers zero-extend their mask.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/lane_onehot_dec.sv
// Lane address to one-hot lane enable; addresses at or beyond LANES decode to all zeros.
module lane_onehot_dec #(
  parameter int ADDR_W = 3,
  parameter int LANES  = 8
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [LANES-1:0]  lane_en
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_en[i] = en & (addr == ADDR_W'(i));
  end

endmodule

// File: rtl/lane_pack_buffer.sv
// Serial-to-parallel lane packer with a double-buffered (assembly + holding) frame output.
// Optional macro LANE_PACK_ERR_EN adds the addr_err pulse output.
module lane_pack_buffer
  import lane_pack_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    w_clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [DATA_W-1:0]       din,
  input  logic [ADDR_W-1:0]       w_addr,
  input  logic                    flush,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [LANES*DATA_W-1:0] frame,
  output logic [LANES-1:0]        frame_mask,
  output logic [ADDR_W:0]         fill_cnt
`ifdef LANE_PACK_ERR_EN
  ,
  output logic                    addr_err
`endif
);

  localparam logic [ADDR_W-1:0] LAST_LANE = ADDR_W'(LANES - 1);
  localparam int                CNT_W     = ADDR_W + 1;

  state_t                  state_q, state_d;
  logic [LANES*DATA_W-1:0] asm_data_q, asm_data_d;
  logic [LANES-1:0]        asm_mask_q, asm_mask_d;
  logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic                    mode_q, mode_d;
  logic [LANES*DATA_W-1:0] frame_q, frame_d;
  logic [LANES-1:0]        frame_mask_q, frame_mask_d;
  logic                    frame_valid_q, frame_valid_d;

  logic                    accept;
  logic                    mode_eff;
  logic [ADDR_W-1:0]       lane_addr;
  logic [LANES-1:0]        lane_en;
  logic [LANES*DATA_W-1:0] wr_data;
  logic [LANES-1:0]        wr_mask;
  logic                    complete;
  logic                    out_free;
  logic [63:0]             mask_ext;

  // Ready is forced low while reset is asserted so every output reads zero during reset.
  assign din_ready = (state_q != PENDING) & rst_n;
  assign accept    = din_valid & din_ready;
  assign mode_eff  = (state_q == EMPTY) ? mode : mode_q;
  assign lane_addr = (mode_eff == MODE_ADDR) ? w_addr : wr_ptr_q;

  lane_onehot_dec #(
    .ADDR_W (ADDR_W),
    .LANES  (LANES)
  ) u_wr_dec (
    .en      (accept),
    .addr    (lane_addr),
    .lane_en (lane_en)
  );

  always_comb begin
    wr_data = asm_data_q;
    for (int i = 0; i < LANES; i++)
      if (lane_en[i]) wr_data[i*DATA_W +: DATA_W] = din;
  end

  assign wr_mask  = asm_mask_q | lane_en;
  // A flush folds in a same-cycle write because it looks at the merged mask.
  assign complete = (accept & (mode_eff == MODE_AUTO) & (wr_ptr_q == LAST_LANE))
                  | (accept & (mode_eff == MODE_ADDR) & (&wr_mask))
                  | (flush & (state_q != PENDING) & (|wr_mask));
  assign out_free = ~frame_valid_q | frame_ready;

  always_comb begin
    state_d       = state_q;
    asm_data_d    = asm_data_q;
    asm_mask_d    = asm_mask_q;
    wr_ptr_d      = wr_ptr_q;
    mode_d        = mode_q;
    frame_d       = frame_q;
    frame_mask_d  = frame_mask_q;
    frame_valid_d = frame_valid_q & ~frame_ready;
    if ((state_q == EMPTY) && (lane_en != '0)) mode_d = mode;
    case (state_q)
      PENDING: begin
        if (frame_ready) begin
          frame_d       = asm_data_q;
          frame_mask_d  = asm_mask_q;
          frame_valid_d = 1'b1;
          asm_data_d    = '0;
          asm_mask_d    = '0;
          state_d       = EMPTY;
        end
      end
      default: begin
        if (complete) begin
          wr_ptr_d = '0;
          if (out_free) begin
            frame_d       = wr_data;
            frame_mask_d  = wr_mask;
            frame_valid_d = 1'b1;
            asm_data_d    = '0;
            asm_mask_d    = '0;
            state_d       = EMPTY;
          end else begin
            asm_data_d = wr_data;
            asm_mask_d = wr_mask;
            state_d    = PENDING;
          end
        end else if (accept) begin
          asm_data_d = wr_data;
          asm_mask_d = wr_mask;
          if (mode_eff == MODE_AUTO) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          state_d = (wr_mask != '0) ? FILLING : EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      asm_data_q    <= '0;
      asm_mask_q    <= '0;
      wr_ptr_q      <= '0;
      mode_q        <= MODE_AUTO;
      frame_q       <= '0;
      frame_mask_q  <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      asm_data_q    <= asm_data_d;
      asm_mask_q    <= asm_mask_d;
      wr_ptr_q      <= wr_ptr_d;
      mode_q        <= mode_d;
      frame_q       <= frame_d;
      frame_mask_q  <= frame_mask_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign frame       = frame_q;
  assign frame_mask  = frame_mask_q;
  assign frame_valid = frame_valid_q;
  assign mask_ext    = 64'(asm_mask_q);
  assign fill_cnt    = CNT_W'(popcount(mask_ext));

`ifdef LANE_PACK_ERR_EN
  logic addr_err_q;
  logic addr_err_d;

  // Flags addressed writes that decode to no lane or land on a lane already written.
  assign addr_err_d = accept & (mode_eff == MODE_ADDR)
                    & ((lane_en == '0) | (|(lane_en & asm_mask_q)));

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) addr_err_q <= 1'b0;
    else        addr_err_q <= addr_err_d;
  end

  assign addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_lane_pack_buffer.sv
// Bench for lane_pack_buffer: vector table, directed corner sequences and a queue-based random model.
module tb_lane_pack_buffer;

  logic w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  logic        rst_n;
  logic        mode, din_valid, din_ready, flush, frame_valid, frame_ready;
  logic [7:0]  din;
  logic [2:0]  w_addr;
  logic [63:0] frame;
  logic [7:0]  frame_mask;
  logic [3:0]  fill_cnt;

  logic        mode5, v5, rdy5, fl5, fv5, fr5;
  logic [11:0] d5;
  logic [2:0]  a5;
  logic [59:0] frame5;
  logic [4:0]  mask5;
  logic [3:0]  fc5;
`ifdef LANE_PACK_ERR_EN
  logic        addr_err, addr_err5;
`endif

  lane_pack_buffer #(.DATA_W(8), .LANES(8), .ADDR_W(3)) dut (
    .w_clk(w_clk), .rst_n(rst_n), .mode(mode), .din_valid(din_valid), .din_ready(din_ready),
    .din(din), .w_addr(w_addr), .flush(flush), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame(frame), .frame_mask(frame_mask), .fill_cnt(fill_cnt)
`ifdef LANE_PACK_ERR_EN
    , .addr_err(addr_err)
`endif
  );

  lane_pack_buffer #(.DATA_W(12), .LANES(5), .ADDR_W(3)) dut5 (
    .w_clk(w_clk), .rst_n(rst_n), .mode(mode5), .din_valid(v5), .din_ready(rdy5),
    .din(d5), .w_addr(a5), .flush(fl5), .frame_valid(fv5),
    .frame_ready(fr5), .frame(frame5), .frame_mask(mask5), .fill_cnt(fc5)
`ifdef LANE_PACK_ERR_EN
    , .addr_err(addr_err5)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge w_clk);
    #1;
  endtask

  task automatic idle_inputs;
    din_valid = 0; din = '0; mode = 0; w_addr = '0; flush = 0; frame_ready = 0;
    v5 = 0; d5 = '0; mode5 = 0; a5 = '0; fl5 = 0; fr5 = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [63:0] ef,
                         input logic [7:0] em, input logic [3:0] efc, input logic erdy);
    chk({tag, ".valid"}, 64'(frame_valid), 64'(ev));
    chk({tag, ".frame"}, frame, ef);
    chk({tag, ".mask"},  64'(frame_mask), 64'(em));
    chk({tag, ".fill"},  64'(fill_cnt), 64'(efc));
    chk({tag, ".ready"}, 64'(din_ready), 64'(erdy));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        md;
    logic [2:0]  a;
    logic        fl;
    logic        fr;
    logic        ev;
    logic [63:0] ef;
    logic [7:0]  em;
    logic [3:0]  efc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic md,
                              input logic [2:0] a, input logic fl, input logic fr,
                              input logic ev, input logic [63:0] ef, input logic [7:0] em,
                              input logic [3:0] efc);
    vec_t r;
    r = '{v:v, d:d, md:md, a:a, fl:fl, fr:fr, ev:ev, ef:ef, em:em, efc:efc};
    return r;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] d;
    logic [7:0]  m;
  } fr_t;

  fr_t         q[$];
  logic [7:0]  mv[8];
  bit          mset[8];
  int          mptr;
  bit          mmode;
  logic [63:0] m_frame;
  logic [7:0]  m_mask;

  function automatic int set_count();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(mset[i]);
    return c;
  endfunction

  task automatic model_clear;
    for (int i = 0; i < 8; i++) begin mv[i] = '0; mset[i] = 0; end
    mptr = 0;
  endtask

  task automatic model_reset;
    q.delete();
    model_clear();
    mmode = 0;
    m_frame = '0;
    m_mask = '0;
  endtask

  // One clock edge: write lands, completion is decided, consumer pops, new frame queues.
  task automatic model_step;
    bit  acc, done, m;
    int  lane;
    fr_t f;
    acc  = din_valid && (q.size() < 2);
    m    = (set_count() > 0) ? mmode : mode;
    done = 0;
    if (acc) begin
      lane = m ? int'(w_addr) : mptr;
      if (lane < 8) begin
        if (set_count() == 0) mmode = mode;
        mv[lane] = din;
        mset[lane] = 1;
        if (!m) begin
          mptr++;
          if (lane == 7) done = 1;
        end else if (set_count() == 8) done = 1;
      end
    end
    if (flush && set_count() > 0) done = 1;
    if (q.size() > 0 && frame_ready) void'(q.pop_front());
    if (done) begin
      f.d = '0;
      f.m = '0;
      for (int i = 0; i < 8; i++) begin
        f.d[8*i +: 8] = mv[i];
        f.m[i] = mset[i];
      end
      q.push_back(f);
      model_clear();
    end
    if (q.size() > 0) begin
      m_frame = q[0].d;
      m_mask  = q[0].m;
    end
  endtask

  // ---------------- test sequence ----------------
  logic [59:0] e5;

  initial begin
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    chk_out("reset", 1'b0, 64'h0, 8'h00, 4'd0, 1'b0);
    chk("reset5.valid", 64'(fv5), 64'(0));
    chk("reset5.fill", 64'(fc5), 64'(0));
    rst_n = 1;
    tick();
    chk("release.ready", 64'(din_ready), 64'(1));

    // Auto frame, addressed overwrite, flush corners, mode latching.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 8'(17 * (i + 1)), 0, 0, 0, 1, i == 7,
                       (i == 7) ? 64'h8877665544332211 : 64'h0,
                       (i == 7) ? 8'hFF : 8'h00, (i == 7) ? 4'd0 : 4'(i + 1)));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 64'h8877665544332211, 8'hFF, 4'd0));
    tbl.push_back(mk(1, 8'hA5, 1, 5, 0, 1, 0, 64'h8877665544332211, 8'hFF, 4'd1));
    tbl.push_back(mk(1, 8'h22, 1, 2, 0, 1, 0, 64'h8877665544332211, 8'hFF, 4'd2));
    tbl.push_back(mk(1, 8'h55, 1, 5, 0, 1, 0, 64'h8877665544332211, 8'hFF, 4'd2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 64'h0000550000220000, 8'h24, 4'd0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 64'h0000550000220000, 8'h24, 4'd0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 64'h0000550000220000, 8'h24, 4'd0));
    tbl.push_back(mk(1, 8'h7E, 1, 0, 1, 1, 1, 64'h000000000000007E, 8'h01, 4'd0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 64'h000000000000007E, 8'h01, 4'd0));
    tbl.push_back(mk(1, 8'h33, 1, 3, 0, 1, 0, 64'h000000000000007E, 8'h01, 4'd1));
    tbl.push_back(mk(1, 8'h66, 0, 6, 0, 1, 0, 64'h000000000000007E, 8'h01, 4'd2));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 64'h0066000033000000, 8'h48, 4'd0));

    foreach (tbl[i]) begin
      din_valid = tbl[i].v; din = tbl[i].d; mode = tbl[i].md; w_addr = tbl[i].a;
      flush = tbl[i].fl; frame_ready = tbl[i].fr;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ef, tbl[i].em, tbl[i].efc, 1'b1);
    end

    // Backpressure: 16 auto words with the consumer stalled.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("bp.ready%0d", k), 64'(din_ready), 64'(1));
      din_valid = 1; din = 8'(k); mode = 0;
      tick();
      if (k == 8) chk_out("bp.first", 1'b1, 64'h0807060504030201, 8'hFF, 4'd0, 1'b1);
    end
    din = 8'hEE;
    tick();
    din_valid = 0;
    chk_out("bp.stall", 1'b1, 64'h0807060504030201, 8'hFF, 4'd8, 1'b0);
    frame_ready = 1;
    tick();
    chk_out("bp.second", 1'b1, 64'h100F0E0D0C0B0A09, 8'hFF, 4'd0, 1'b1);
    frame_ready = 0;

    // Async reset while a frame is held and another is half built.
    for (int k = 0; k < 3; k++) begin
      din_valid = 1; din = 8'hC0 + 8'(k);
      tick();
    end
    din_valid = 0;
    chk("mid.fill", 64'(fill_cnt), 64'(3));
    rst_n = 0;
    #1;
    chk_out("async_rst", 1'b0, 64'h0, 8'h00, 4'd0, 1'b0);
    tick();
    rst_n = 1;
    tick();
    frame_ready = 1;
    for (int k = 0; k < 8; k++) begin
      din_valid = 1; din = 8'hA0 + 8'(k); mode = 0;
      tick();
    end
    din_valid = 0;
    chk_out("post_rst", 1'b1, 64'hA7A6A5A4A3A2A1A0, 8'hFF, 4'd0, 1'b1);
    frame_ready = 0;

    // Five 12-bit lanes: out-of-range drop and duplicate lane write.
    do_reset();
    v5 = 1; mode5 = 1; a5 = 3'd6; d5 = 12'hFFF;
    tick();
    chk("l5.drop.fill", 64'(fc5), 64'(0));
    chk("l5.drop.valid", 64'(fv5), 64'(0));
`ifdef LANE_PACK_ERR_EN
    chk("l5.drop.err", 64'(addr_err5), 64'(1));
`endif
    v5 = 0;
    tick();
`ifdef LANE_PACK_ERR_EN
    chk("l5.err_clear", 64'(addr_err5), 64'(0));
`endif
    v5 = 1; a5 = 3'd4; d5 = 12'h111;
    tick();
    chk("l5.first4.fill", 64'(fc5), 64'(1));
`ifdef LANE_PACK_ERR_EN
    chk("l5.first4.err", 64'(addr_err5), 64'(0));
`endif
    d5 = 12'hABC;
    tick();
    chk("l5.dup4.fill", 64'(fc5), 64'(1));
`ifdef LANE_PACK_ERR_EN
    chk("l5.dup4.err", 64'(addr_err5), 64'(1));
`endif
    fr5 = 1;
    for (int i = 0; i < 4; i++) begin
      a5 = 3'(i); d5 = 12'h100 + 12'(i);
      tick();
    end
    v5 = 0;
    e5 = '0;
    e5[48 +: 12] = 12'hABC;
    for (int i = 0; i < 4; i++) e5[12*i +: 12] = 12'h100 + 12'(i);
    chk("l5.valid", 64'(fv5), 64'(1));
    chk("l5.frame", 64'(frame5), 64'(e5));
    chk("l5.mask", 64'(mask5), 64'(5'h1F));
    chk("l5.fill", 64'(fc5), 64'(0));
    chk("l5.ready", 64'(rdy5), 64'(1));

    // Random traffic against the queue model.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      din_valid   = ($urandom_range(3) != 0);
      din         = 8'($urandom);
      w_addr      = 3'($urandom);
      mode        = ($urandom_range(7) < 3);
      flush       = ($urandom_range(9) == 0);
      frame_ready = ($urandom_range(1) == 1);
      @(posedge w_clk);
      model_step();
      #1;
      chk_out($sformatf("rnd%0d", c), q.size() > 0, m_frame, m_mask,
              4'((q.size() == 2) ? $countones(q[1].m) : set_count()), q.size() < 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
